connect_n_board: RTL and testbench

Parametrised board engine for the Connect-N game: holds the ROWS×COLS two-player board and per-column fill heights, accepts coin drops through a valid/ready handshake, and detects wins by walking all four line directions through the last-placed coin. Detects N-in-a-row for any N, rejects full or invalid columns, detects a draw, and locks after game end until cleared. Sits between the drop-control FSM (column select / enter buttons) and the display multiplexer, which reads cells through a registered read port.

---
 rtl/connect_n_board.sv | 212 +++++++++++++++++++++
 tb/tb_connect_n_board.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect_n_board.sv
`timescale 1ns/1ps
// connect_n_board
//   Connect-N board engine. Holds the ROWS x COLS board and the fill height of
//   each column. A coin is accepted through a valid/ready handshake. The engine
//   places the coin, then walks the four line directions through that coin one
//   cell per cycle to detect a win. It also detects a draw (board full) and
//   rejects drops into a full or invalid column. After a win or a draw the
//   engine locks until i_clr.
// Ports
//   i_clk, i_rst              clock, async active-high reset
//   i_clr                     synchronous new-game clear
//   i_drop_valid/o_drop_ready drop handshake (ready only in IDLE)
//   i_drop_col, i_drop_player drop target column and coin owner
//   o_done                    one-cycle pulse, the outcome below is valid
//   o_result                  00 placed, 01 win, 10 rejected, 11 draw
//   o_win_player, o_land_row  player and landing row of the last placed coin
//   i_rd_col, i_rd_row        display read address
//   o_rd_cell                 registered cell value (00 empty, 01 p0, 10 p1)
module connect_n_board #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_drop_valid,
  output logic          o_drop_ready,
  input  logic [CW-1:0] i_drop_col,
  input  logic          i_drop_player,
  output logic          o_done,
  output logic [1:0]    o_result,
  output logic          o_win_player,
  output logic [RW-1:0] o_land_row,
  input  logic [CW-1:0] i_rd_col,
  input  logic [RW-1:0] i_rd_row,
  output logic [1:0]    o_rd_cell
);

  localparam int HW = $clog2(ROWS + 1);
  localparam int PW = $clog2(ROWS * COLS + 1);
  localparam int SW = $clog2(WIN_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLACE = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_LOCK  = 3'd4;

  localparam logic [CW:0]        COLS_W = (CW + 1)'(COLS);
  localparam logic [RW:0]        ROWS_W = (RW + 1)'(ROWS);
  localparam logic signed [15:0] COLS_S = 16'(COLS);
  localparam logic signed [15:0] ROWS_S = 16'(ROWS);

  logic [1:0]    r_board [ROWS][COLS];
  logic [HW-1:0] r_height [COLS];
  logic [PW-1:0] r_placed;

  logic [2:0]    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_land;
  logic          r_player;
  logic [1:0]    r_dir;
  logic          r_side;
  logic [SW-1:0] r_step;
  logic [SW-1:0] r_cnt;
  logic          r_done;
  logic [1:0]    r_result;
  logic          r_win_player;
  logic [RW-1:0] r_land_out;
  logic [1:0]    r_rd_cell;

  logic                w_col_bad, w_reject, w_rd_ok;
  logic [HW-1:0]       w_hcur;
  logic [1:0]          w_pcode;
  logic signed [15:0]  w_off, w_dcol, w_drow, w_cc, w_cr;
  logic                w_in, w_hit;

  always_comb begin
    w_col_bad = ({1'b0, i_drop_col} >= COLS_W);
    w_reject  = w_col_bad || (r_height[i_drop_col] == HW'(ROWS));
    w_hcur    = r_height[r_col];
    w_pcode   = r_player ? 2'b10 : 2'b01;
    w_rd_ok   = ({1'b0, i_rd_col} < COLS_W) && ({1'b0, i_rd_row} < ROWS_W);

    // Candidate cell = landing cell + step * direction, mirrored on the - side.
    w_off = $signed({{(16 - SW){1'b0}}, r_step});
    case (r_dir)
      2'd0:    begin w_dcol = w_off; w_drow = '0;     end
      2'd1:    begin w_dcol = '0;    w_drow = w_off;  end
      2'd2:    begin w_dcol = w_off; w_drow = w_off;  end
      default: begin w_dcol = w_off; w_drow = -w_off; end
    endcase
    if (r_side) begin
      w_dcol = -w_dcol;
      w_drow = -w_drow;
    end
    w_cc  = $signed({{(16 - CW){1'b0}}, r_col}) + w_dcol;
    w_cr  = $signed({{(16 - RW){1'b0}}, r_land}) + w_drow;
    w_in  = (w_cc >= 16'sd0) && (w_cc < COLS_S) && (w_cr >= 16'sd0) && (w_cr < ROWS_S);
    w_hit = 1'b0;
    if (w_in) w_hit = (r_board[w_cr[RW-1:0]][w_cc[CW-1:0]] == w_pcode);
  end

  // Board storage, heights, placed count and display read port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_clr) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_board[r][c] <= 2'b00;
      for (int c = 0; c < COLS; c++)
        r_height[c] <= '0;
      r_placed  <= '0;
      r_rd_cell <= 2'b00;
    end else begin
      if (r_state == S_PLACE) begin
        r_board[w_hcur[RW-1:0]][r_col] <= w_pcode;
        r_height[r_col]                <= w_hcur + 1'b1;
        r_placed                       <= r_placed + 1'b1;
      end
      r_rd_cell <= w_rd_ok ? r_board[i_rd_row][i_rd_col] : 2'b00;
    end
  end

  // Control FSM. A SCAN cycle either extends the current half-walk or ends it;
  // the end of a - side half-walk moves to the next direction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_land       <= '0;
      r_player     <= 1'b0;
      r_dir        <= '0;
      r_side       <= 1'b0;
      r_step       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_result     <= 2'b00;
      r_win_player <= 1'b0;
      r_land_out   <= '0;
    end else if (i_clr) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_drop_valid) begin
            r_col    <= i_drop_col;
            r_player <= i_drop_player;
            if (w_reject) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= 2'b10;
            end else begin
              r_state <= S_PLACE;
            end
          end
        end
        S_PLACE: begin
          r_land  <= w_hcur[RW-1:0];
          r_dir   <= 2'd0;
          r_side  <= 1'b0;
          r_step  <= SW'(1);
          r_cnt   <= SW'(1);
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (w_hit && (r_cnt + 1'b1 == SW'(WIN_LEN))) begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_result     <= 2'b01;
            r_win_player <= r_player;
            r_land_out   <= r_land;
          end else if (w_hit && (r_step != SW'(WIN_LEN - 1))) begin
            r_cnt  <= r_cnt + 1'b1;
            r_step <= r_step + 1'b1;
          end else begin
            if (w_hit) r_cnt <= r_cnt + 1'b1;
            r_step <= SW'(1);
            if (!r_side) begin
              r_side <= 1'b1;
            end else if (r_dir == 2'd3) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_result     <= (r_placed == PW'(ROWS * COLS)) ? 2'b11 : 2'b00;
              r_win_player <= r_player;
              r_land_out   <= r_land;
            end else begin
              r_side <= 1'b0;
              r_dir  <= r_dir + 1'b1;
              r_cnt  <= SW'(1);
            end
          end
        end
        S_DONE:  r_state <= r_result[0] ? S_LOCK : S_IDLE;
        S_LOCK:  r_state <= S_LOCK;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_drop_ready = (r_state == S_IDLE);
  assign o_done       = r_done;
  assign o_result     = r_result;
  assign o_win_player = r_win_player;
  assign o_land_row   = r_land_out;
  assign o_rd_cell    = r_rd_cell;

endmodule

// File: tb/tb_connect_n_board.sv
`timescale 1ns/1ps
// Bench for connect_n_board: a reference board model produces the expected
// outcome of every drop; expectations are queued at drive time and compared
// by a monitor when o_done pulses.
module tb_connect_n_board;
  localparam int COLS = 7;
  localparam int ROWS = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       drop_valid = 1'b0;
  logic       drop_ready;
  logic [2:0] drop_col = '0;
  logic       drop_player = 1'b0;
  logic       done;
  logic [1:0] result;
  logic       win_player;
  logic [2:0] land_row;
  logic [2:0] rd_col = '0;
  logic [2:0] rd_row = '0;
  logic [1:0] rd_cell;

  connect_n_board #(.COLS(COLS), .ROWS(ROWS), .WIN_LEN(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr),
    .i_drop_valid(drop_valid), .o_drop_ready(drop_ready),
    .i_drop_col(drop_col), .i_drop_player(drop_player),
    .o_done(done), .o_result(result), .o_win_player(win_player),
    .o_land_row(land_row), .i_rd_col(rd_col), .i_rd_row(rd_row),
    .o_rd_cell(rd_cell)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0] res;
    logic       wp;
    logic [2:0] lr;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  // Reference board model: 0 empty, 1 player 0, 2 player 1.
  int mb[COLS][ROWS];
  int mh[COLS];
  int mplaced;

  function automatic void model_clear();
    for (int c = 0; c < COLS; c++) begin
      mh[c] = 0;
      for (int r = 0; r < ROWS; r++) mb[c][r] = 0;
    end
    mplaced = 0;
  endfunction

  function automatic int run_len(int c, int r, int dc, int dr, int code);
    int n = 0;
    int x = c + dc;
    int y = r + dr;
    while (x >= 0 && x < COLS && y >= 0 && y < ROWS && mb[x][y] == code) begin
      n++;
      x += dc;
      y += dr;
    end
    return n;
  endfunction

  function automatic bit model_win(int c, int r, int code);
    int dcs[4] = '{1, 0, 1, 1};
    int drs[4] = '{0, 1, 1, -1};
    for (int d = 0; d < 4; d++)
      if (1 + run_len(c, r, dcs[d], drs[d], code) + run_len(c, r, -dcs[d], -drs[d], code) >= 4)
        return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        if (e.res != 2'b10) begin
          chk("win_player", 32'(win_player), 32'(e.wp));
          chk("land_row", 32'(land_row), 32'(e.lr));
        end
        if (e.lat >= 0) chk("done_latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
  end

  task automatic drop(input int col, input bit pl, input int lat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!drop_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!drop_ready) chk("ready_timeout", 32'd0, 32'd1);
    e.wp  = pl;
    e.lat = lat;
    e.lr  = '0;
    if (col >= COLS || mh[col] == ROWS) begin
      e.res = 2'b10;
    end else begin
      e.lr = 3'(mh[col]);
      mb[col][mh[col]] = pl ? 2 : 1;
      mh[col]++;
      mplaced++;
      if (model_win(col, int'(e.lr), pl ? 2 : 1)) e.res = 2'b01;
      else if (mplaced == ROWS * COLS)            e.res = 2'b11;
      else                                        e.res = 2'b00;
    end
    sb_q.push_back(e);
    drop_valid  = 1'b1;
    drop_col    = 3'(col);
    drop_player = pl;
    @(posedge clk);
    #1;
    acc_cyc    = cyc;
    drop_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  task automatic rd(input int c, input int r, input logic [1:0] exp);
    @(negedge clk);
    rd_col = 3'(c);
    rd_row = 3'(r);
    @(posedge clk);
    #1;
    chk($sformatf("rd_cell(%0d,%0d)", c, r), 32'(rd_cell), 32'(exp));
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
    chk("ready_after_clr", 32'(drop_ready), 32'd1);
  endtask

  task automatic poke_locked(input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drop_valid = 1'b1;
      drop_col   = 3'd1;
      chk(tag, 32'(drop_ready), 32'd0);
    end
    @(negedge clk);
    drop_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    #12;
    rst = 1'b0;
    #1;
    chk("reset_ready", 32'(drop_ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_win_player", 32'(win_player), 32'd0);
    chk("reset_land_row", 32'(land_row), 32'd0);
    chk("reset_rd_cell", 32'(rd_cell), 32'd0);

    // First coin on an empty board: eight single-cycle half-walks.
    drop(3, 1'b0, 9);
    rd(3, 0, 2'b01);
    rd(3, 1, 2'b00);
    rd(7, 0, 2'b00);
    rd(3, 6, 2'b00);

    // Vertical win for player 1 in column 0, then lock.
    do_clr();
    drop(0, 1'b1, -1);
    drop(5, 1'b0, -1);
    drop(0, 1'b1, -1);
    drop(6, 1'b0, -1);
    drop(0, 1'b1, -1);
    drop(5, 1'b0, -1);
    drop(0, 1'b1, -1);
    poke_locked("locked_ready_win");
    rd(1, 0, 2'b00);

    // Full column and invalid column rejects.
    do_clr();
    for (int i = 0; i < ROWS; i++) drop(2, 1'(i % 2), -1);
    drop(2, 1'b0, 0);
    rd(2, 5, 2'b10);
    drop(7, 1'b1, 0);

    // Diagonal (+1,+1) closed by the middle coin.
    do_clr();
    drop(0, 1'b0, -1);
    drop(1, 1'b1, -1);
    drop(1, 1'b0, -1);
    drop(2, 1'b1, -1);
    drop(2, 1'b1, -1);
    drop(3, 1'b1, -1);
    drop(3, 1'b1, -1);
    drop(3, 1'b1, -1);
    drop(3, 1'b0, -1);
    drop(2, 1'b0, -1);
    rd(2, 2, 2'b01);

    // Full board with no line longer than two: draw on the last coin.
    do_clr();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        drop(c, 1'((c % 2) ^ ((r / 2) % 2)), -1);
    poke_locked("locked_ready_draw");

    // Clear in the third SCAN cycle suppresses the outcome.
    do_clr();
    @(negedge clk);
    drop_valid = 1'b1;
    drop_col   = 3'd0;
    drop_player = 1'b0;
    @(posedge clk);
    #1;
    drop_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_clear();
    chk("ready_after_midscan_clr", 32'(drop_ready), 32'd1);
    repeat (12) @(posedge clk);
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        rd(c, r, 2'b00);

    // Asynchronous reset in the middle of SCAN.
    @(negedge clk);
    rd_col = 3'd4;
    rd_row = 3'd0;
    drop_valid = 1'b1;
    drop_col   = 3'd4;
    drop_player = 1'b1;
    @(posedge clk);
    #1;
    drop_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rd_cell_before_rst", 32'(rd_cell), 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(drop_ready), 32'd1);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_result", 32'(result), 32'd0);
    chk("async_rst_win_player", 32'(win_player), 32'd0);
    chk("async_rst_land_row", 32'(land_row), 32'd0);
    chk("async_rst_rd_cell", 32'(rd_cell), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
